vend_change_dispenser: RTL and testbench

- Pays out change for the vending machine by driving a coin hopper one coin at a time.
- Accepts a change amount in nickel units (5c) over a valid/ready request interface.
- Pays greedily (quarter, then dime, then nickel) from an internal coin inventory.
- Each eject is confirmed by a hopper sensor pulse; unconfirmed ejects time out and flag a fault.

---
 rtl/vend_change_dispenser.sv | 218 +++++++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser.sv
// ---------------------------------------------------------------------------
// vend_change_dispenser
//
// Pays out change by driving a coin hopper one coin at a time. The owed
// amount is given in nickel units. Coins are chosen greedily: quarter, then
// dime, then nickel, limited by an internal inventory. Each eject must be
// confirmed by a hopper sensor pulse. An eject that is not confirmed in
// time sets a sticky fault and ends the payout short.
//
// State table:
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_IDLE     | ready for a request, inventory may be loaded
//   ST_SELECT   | pick the next coin, or finish when none fits
//   ST_EJECT    | one-cycle eject pulse for the chosen coin, timer cleared
//   ST_WAIT_ACK | wait for coin_seen, bounded by TIMEOUT cycles
//   ST_DONE     | one-cycle done pulse, short is valid
//
// Ports:
//   clk, reset                  clock (rising edge), sync active-low reset
//   req_valid/req_ready         change request handshake
//   req_amount                  change owed, nickel units
//   load_inv, inv_*_in          inventory load (taken only in IDLE)
//   eject_q/eject_d/eject_n     one-cycle hopper eject pulses
//   coin_seen                   hopper sensor, one coin left the hopper
//   busy, done, short           status; short is valid while done is high
//   remaining                   amount still unpaid
//   fault                       sticky hopper timeout flag
//   inv_q/inv_d/inv_n           current inventory
// ---------------------------------------------------------------------------
module vend_change_dispenser #(
    parameter int AMT_W   = 8,
    parameter int INV_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    input  logic             load_inv,
    input  logic [INV_W-1:0] inv_q_in,
    input  logic [INV_W-1:0] inv_d_in,
    input  logic [INV_W-1:0] inv_n_in,
    output logic             eject_q,
    output logic             eject_d,
    output logic             eject_n,
    input  logic             coin_seen,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [AMT_W-1:0] remaining,
    output logic             fault,
    output logic [INV_W-1:0] inv_q,
    output logic [INV_W-1:0] inv_d,
    output logic [INV_W-1:0] inv_n
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [AMT_W-1:0] VAL_Q = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_D = AMT_W'(2);
    localparam logic [AMT_W-1:0] VAL_N = AMT_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    state_t            state_q, state_d;
    coin_t             coin_q, coin_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic [INV_W-1:0]  inv_qtr_q, inv_qtr_d;
    logic [INV_W-1:0]  inv_dime_q, inv_dime_d;
    logic [INV_W-1:0]  inv_nick_q, inv_nick_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              short_q, short_d;
    logic              fault_q, fault_d;
    logic [AMT_W-1:0]  coin_val;

    always_comb begin
        coin_val = VAL_N;
        case (coin_q)
            COIN_Q:  coin_val = VAL_Q;
            COIN_D:  coin_val = VAL_D;
            default: coin_val = VAL_N;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        coin_d     = coin_q;
        rem_d      = rem_q;
        inv_qtr_d  = inv_qtr_q;
        inv_dime_d = inv_dime_q;
        inv_nick_d = inv_nick_q;
        timer_d    = timer_q;
        short_d    = short_q;
        fault_d    = fault_q;

        case (state_q)
            ST_IDLE: begin
                // A request in the same cycle as a load wins; the load is lost.
                if (req_valid) begin
                    rem_d   = req_amount;
                    short_d = 1'b0;
                    state_d = ST_SELECT;
                end else if (load_inv) begin
                    inv_qtr_d  = inv_q_in;
                    inv_dime_d = inv_d_in;
                    inv_nick_d = inv_n_in;
                    fault_d    = 1'b0;
                end
            end

            ST_SELECT: begin
                if (rem_q == '0) begin
                    short_d = 1'b0;
                    state_d = ST_DONE;
                end else if (rem_q >= VAL_Q && inv_qtr_q != '0) begin
                    coin_d  = COIN_Q;
                    state_d = ST_EJECT;
                end else if (rem_q >= VAL_D && inv_dime_q != '0) begin
                    coin_d  = COIN_D;
                    state_d = ST_EJECT;
                end else if (inv_nick_q != '0) begin
                    // rem_q is non-zero here, so it is at least one nickel.
                    coin_d  = COIN_N;
                    state_d = ST_EJECT;
                end else begin
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end
            end

            ST_EJECT: begin
                timer_d = '0;
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                // A confirmation on the last allowed cycle still counts.
                if (coin_seen) begin
                    rem_d = rem_q - coin_val;
                    case (coin_q)
                        COIN_Q:  inv_qtr_d  = inv_qtr_q - INV_W'(1);
                        COIN_D:  inv_dime_d = inv_dime_q - INV_W'(1);
                        default: inv_nick_d = inv_nick_q - INV_W'(1);
                    endcase
                    state_d = ST_SELECT;
                end else if (timer_q == TMR_LAST) begin
                    fault_d = 1'b1;
                    short_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            coin_q     <= COIN_Q;
            rem_q      <= '0;
            inv_qtr_q  <= '0;
            inv_dime_q <= '0;
            inv_nick_q <= '0;
            timer_q    <= '0;
            short_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            coin_q     <= coin_d;
            rem_q      <= rem_d;
            inv_qtr_q  <= inv_qtr_d;
            inv_dime_q <= inv_dime_d;
            inv_nick_q <= inv_nick_d;
            timer_q    <= timer_d;
            short_q    <= short_d;
            fault_q    <= fault_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign short     = short_q;
    assign remaining = rem_q;
    assign fault     = fault_q;
    assign inv_q     = inv_qtr_q;
    assign inv_d     = inv_dime_q;
    assign inv_n     = inv_nick_q;

    assign eject_q = (state_q == ST_EJECT) && (coin_q == COIN_Q);
    assign eject_d = (state_q == ST_EJECT) && (coin_q == COIN_D);
    assign eject_n = (state_q == ST_EJECT) && (coin_q == COIN_N);

endmodule

// File: tb/tb_vend_change_dispenser.sv
module tb_vend_change_dispenser;

    localparam int AMT_W   = 8;
    localparam int INV_W   = 6;
    localparam int TIMEOUT = 16;

    localparam logic [2:0] EJ_Q = 3'b100;
    localparam logic [2:0] EJ_D = 3'b010;
    localparam logic [2:0] EJ_N = 3'b001;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             load_inv;
    logic [INV_W-1:0] inv_q_in, inv_d_in, inv_n_in;
    logic             eject_q, eject_d, eject_n;
    logic             coin_seen;
    logic             busy, done, short, fault;
    logic [AMT_W-1:0] remaining;
    logic [INV_W-1:0] inv_q, inv_d, inv_n;

    typedef struct {
        logic [2:0]       ej;
        logic [AMT_W-1:0] rem;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int busy_err = 0;
    int done_err = 0;

    vend_change_dispenser #(
        .AMT_W  (AMT_W),
        .INV_W  (INV_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_amount(req_amount),
        .req_ready (req_ready),
        .load_inv  (load_inv),
        .inv_q_in  (inv_q_in),
        .inv_d_in  (inv_d_in),
        .inv_n_in  (inv_n_in),
        .eject_q   (eject_q),
        .eject_d   (eject_d),
        .eject_n   (eject_n),
        .coin_seen (coin_seen),
        .busy      (busy),
        .done      (done),
        .short     (short),
        .remaining (remaining),
        .fault     (fault),
        .inv_q     (inv_q),
        .inv_d     (inv_d),
        .inv_n     (inv_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_inv(input string tag, input int q, input int d, input int n);
        chk({tag, "_inv_q"}, 32'(inv_q), 32'(q));
        chk({tag, "_inv_d"}, 32'(inv_d), 32'(d));
        chk({tag, "_inv_n"}, 32'(inv_n), 32'(n));
    endtask

    task automatic load(input int q, input int d, input int n);
        @(negedge clk);
        load_inv = 1'b1;
        inv_q_in = INV_W'(q);
        inv_d_in = INV_W'(d);
        inv_n_in = INV_W'(n);
        @(negedge clk);
        load_inv = 1'b0;
        chk_inv("load", q, d, n);
    endtask

    // Cycle numbers count negedges after the accepting posedge: the SELECT
    // cycle following acceptance is cycle 1.
    task automatic run_req(input logic [AMT_W-1:0] amt, input int ack_dly,
                           input int poke_cyc, input int budget,
                           output bit got_done, output logic sh,
                           output logic [AMT_W-1:0] rem_done,
                           output int done_cyc, output int last_ej_cyc);
        int   ack_cnt;
        bit   pending;
        exp_t e;
        logic [2:0] ejs;
        got_done    = 1'b0;
        sh          = 1'b0;
        rem_done    = '0;
        done_cyc    = -1;
        last_ej_cyc = -1;
        pending     = 1'b0;
        ack_cnt     = 0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid  = 1'b0;
        req_amount = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            coin_seen = 1'b0;
            load_inv  = 1'b0;
            req_valid = 1'b0;
            if (busy !== 1'b1 || req_ready !== 1'b0) busy_err++;
            ejs = {eject_q, eject_d, eject_n};
            if (ejs != 3'b000) begin
                last_ej_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'(ejs), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("eject_coin", 32'(ejs), 32'(e.ej));
                    chk("eject_rem", 32'(remaining), 32'(e.rem));
                end
                pending = (ack_dly >= 0);
                ack_cnt = ack_dly;
            end else if (pending) begin
                if (ack_cnt == 0) begin
                    coin_seen = 1'b1;
                    pending   = 1'b0;
                end else begin
                    ack_cnt--;
                end
            end
            if (cyc == poke_cyc) begin
                load_inv   = 1'b1;
                inv_q_in   = INV_W'(0);
                inv_d_in   = INV_W'(9);
                inv_n_in   = INV_W'(9);
                req_valid  = 1'b1;
                req_amount = AMT_W'(7);
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                sh       = short;
                rem_done = remaining;
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        coin_seen  = 1'b0;
        load_inv   = 1'b0;
        req_valid  = 1'b0;
        req_amount = '0;
        chk("done_in_budget", 32'(got_done), 32'd1);
        chk("sb_leftover", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    bit               g_done;
    logic             g_short;
    logic [AMT_W-1:0] g_rem;
    int               g_done_cyc, g_ej_cyc;

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_amount = '0;
        load_inv   = 1'b0;
        inv_q_in   = '0;
        inv_d_in   = '0;
        inv_n_in   = '0;
        coin_seen  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_short", 32'(short), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_eject", 32'({eject_q, eject_d, eject_n}), 32'd0);
        chk_inv("rst", 0, 0, 0);
        reset = 1'b1;

        // Greedy q, d, n with coin_seen two cycles into each WAIT_ACK
        load(5, 5, 5);
        sb.push_back('{EJ_Q, AMT_W'(8)});
        sb.push_back('{EJ_D, AMT_W'(3)});
        sb.push_back('{EJ_N, AMT_W'(1)});
        run_req(AMT_W'(8), 2, -1, 200, g_done, g_short, g_rem, g_done_cyc, g_ej_cyc);
        chk("t1_short", 32'(g_short), 32'd0);
        chk("t1_rem", 32'(g_rem), 32'd0);
        chk("t1_last_eject_cyc", 32'(g_ej_cyc), 32'd12);
        chk("t1_done_cyc", 32'(g_done_cyc), 32'd17);
        chk_inv("t1", 4, 4, 4);
        @(negedge clk);
        chk("t1_ready_after_done", 32'(req_ready), 32'd1);

        // Short payout: two nickels only
        load(0, 0, 2);
        sb.push_back('{EJ_N, AMT_W'(3)});
        sb.push_back('{EJ_N, AMT_W'(2)});
        run_req(AMT_W'(3), 0, -1, 100, g_done, g_short, g_rem, g_done_cyc, g_ej_cyc);
        chk("t2_short", 32'(g_short), 32'd1);
        chk("t2_rem", 32'(g_rem), 32'd1);
        chk("t2_done_cyc", 32'(g_done_cyc), 32'd8);
        chk("t2_fault", 32'(fault), 32'd0);
        chk_inv("t2", 0, 0, 0);

        // Hopper timeout
        load(1, 0, 0);
        sb.push_back('{EJ_Q, AMT_W'(5)});
        run_req(AMT_W'(5), -1, -1, 100, g_done, g_short, g_rem, g_done_cyc, g_ej_cyc);
        chk("t3_short", 32'(g_short), 32'd1);
        chk("t3_rem", 32'(g_rem), 32'd5);
        chk("t3_done_after_wait", 32'(g_done_cyc - (g_ej_cyc + 1)), 32'(TIMEOUT));
        chk("t3_fault", 32'(fault), 32'd1);
        chk_inv("t3", 1, 0, 0);

        // Zero amount while fault is set: still served, fault stays
        run_req(AMT_W'(0), 0, -1, 20, g_done, g_short, g_rem, g_done_cyc, g_ej_cyc);
        chk("t4_done_cyc", 32'(g_done_cyc), 32'd2);
        chk("t4_no_eject", 32'(g_ej_cyc), 32'hFFFF_FFFF);
        chk("t4_short", 32'(g_short), 32'd0);
        chk("t4_rem", 32'(g_rem), 32'd0);
        chk("t4_fault_sticky", 32'(fault), 32'd1);
        load(0, 2, 0);
        chk("t4_fault_cleared", 32'(fault), 32'd0);

        // Busy ignores load_inv and a new request
        sb.push_back('{EJ_D, AMT_W'(4)});
        sb.push_back('{EJ_D, AMT_W'(2)});
        run_req(AMT_W'(4), 1, 3, 100, g_done, g_short, g_rem, g_done_cyc, g_ej_cyc);
        chk("t5_short", 32'(g_short), 32'd0);
        chk("t5_rem", 32'(g_rem), 32'd0);
        chk("t5_done_cyc", 32'(g_done_cyc), 32'd10);
        chk_inv("t5", 0, 0, 0);
        chk("busy_ready_errors", 32'(busy_err), 32'd0);
        @(negedge clk);
        chk("t5_ready_after_done", 32'(req_ready), 32'd1);
        chk("t5_idle_after_done", 32'(busy), 32'd0);

        // Request and load together in IDLE: the request wins
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = AMT_W'(0);
        load_inv   = 1'b1;
        inv_q_in   = INV_W'(7);
        inv_d_in   = INV_W'(7);
        inv_n_in   = INV_W'(7);
        @(negedge clk);
        req_valid = 1'b0;
        load_inv  = 1'b0;
        chk("t6_accepted", 32'(busy), 32'd1);
        chk_inv("t6", 0, 0, 0);
        @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);

        // Reset during WAIT_ACK
        load(1, 0, 0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_amount = AMT_W'(5);
        @(negedge clk);
        req_valid  = 1'b0;
        @(negedge clk);
        chk("t7_eject_q", 32'({eject_q, eject_d, eject_n}), 32'(EJ_Q));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t7_ready", 32'(req_ready), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_rem", 32'(remaining), 32'd0);
        chk_inv("t7", 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            if (done !== 1'b0) done_err++;
            @(negedge clk);
        end
        chk("t7_no_done", 32'(done_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
